// File: rtl/clk_en_sched_pkg.sv
// Shared types and constants for the clock-enable scheduler.
package clk_en_sched_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_RUN  = 2'd2
  } sched_state_e;

  // Number of cycles spent in WAKE before ticks start.
  localparam int unsigned WAKE_CYC = 4;
  localparam int unsigned WAKE_W   = 2;

  // True on the last WAKE cycle.
  function automatic logic wake_last(input logic [WAKE_W-1:0] cnt);
    return cnt == WAKE_W'(WAKE_CYC - 1);
  endfunction

endpackage

// File: rtl/clk_en_sched_div.sv
// Programmable tick divider: period counter, active ratio and pending ratio.
// A ratio strobed while running is held until the current period ends, so a
// period is never truncated; a strobe on the tick cycle itself wins.
module clk_en_sched_div #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_div_vld,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] pend_q;
  logic             pend_vld_q;

  assign tick = run & (cnt_q == div_q);

  // Period counter and ratio bookkeeping; outside RUN the ratio loads directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= {DIV_W{1'b0}};
      div_q      <= {DIV_W{1'b0}};
      pend_q     <= {DIV_W{1'b0}};
      pend_vld_q <= 1'b0;
    end else if (!run) begin
      cnt_q <= {DIV_W{1'b0}};
      if (cfg_div_vld) begin
        div_q      <= cfg_div;
        pend_q     <= cfg_div;
        pend_vld_q <= 1'b0;
      end
    end else if (tick) begin
      cnt_q <= {DIV_W{1'b0}};
      if (cfg_div_vld) begin
        div_q      <= cfg_div;
        pend_q     <= cfg_div;
        pend_vld_q <= 1'b0;
      end else if (pend_vld_q) begin
        div_q      <= pend_q;
        pend_vld_q <= 1'b0;
      end
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
      if (cfg_div_vld) begin
        pend_q     <= cfg_div;
        pend_vld_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_en_sched.sv
// Clock-enable scheduler: OFF -> WAKE -> RUN sequencing, per-requester grants
// updated only on period boundaries, and idle auto-gating back to OFF.
// Optional feature: define CLK_EN_SCHED_STATS_EN to get a 32-bit tick counter
// on tick_cnt; otherwise tick_cnt is tied to zero.
module clk_en_sched
  import clk_en_sched_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DIV_W  = 8,
  parameter int unsigned IDLE_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_div_vld,
  input  logic [IDLE_W-1:0] cfg_idle,
  output logic [N_REQ-1:0]  gnt,
  output logic              tick,
  output logic [N_REQ-1:0]  ce,
  output logic              busy,
  output logic [31:0]       tick_cnt
);

  sched_state_e      state_q;
  logic [WAKE_W-1:0] wake_cnt_q;
  logic [N_REQ-1:0]  gnt_q;
  logic [IDLE_W-1:0] idle_q;
  logic              busy_q;
  logic              run_s;
  logic              tick_s;
  logic              idle_tick_s;

  assign run_s       = (state_q == ST_RUN);
  assign idle_tick_s = (req == {N_REQ{1'b0}}) && (gnt_q == {N_REQ{1'b0}});

  clk_en_sched_div #(
    .DIV_W(DIV_W)
  ) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run_s),
    .cfg_div     (cfg_div),
    .cfg_div_vld (cfg_div_vld),
    .tick        (tick_s)
  );

  // Sequencer FSM with grant register, idle counter and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OFF;
      wake_cnt_q <= {WAKE_W{1'b0}};
      gnt_q      <= {N_REQ{1'b0}};
      idle_q     <= {IDLE_W{1'b0}};
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_OFF: begin
          wake_cnt_q <= {WAKE_W{1'b0}};
          gnt_q      <= {N_REQ{1'b0}};
          idle_q     <= {IDLE_W{1'b0}};
          if (|req) begin
            state_q <= ST_WAKE;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_OFF;
            busy_q  <= 1'b0;
          end
        end
        ST_WAKE: begin
          busy_q <= 1'b1;
          if (wake_last(wake_cnt_q)) begin
            state_q    <= ST_RUN;
            gnt_q      <= req;
            wake_cnt_q <= {WAKE_W{1'b0}};
          end else begin
            wake_cnt_q <= wake_cnt_q + WAKE_W'(1);
          end
        end
        ST_RUN: begin
          if (tick_s) begin
            gnt_q <= req;
            if (idle_tick_s) begin
              if (idle_q == cfg_idle) begin
                state_q <= ST_OFF;
                busy_q  <= 1'b0;
                idle_q  <= {IDLE_W{1'b0}};
              end else begin
                idle_q <= idle_q + IDLE_W'(1);
              end
            end else begin
              idle_q <= {IDLE_W{1'b0}};
            end
          end
        end
        default: begin
          state_q    <= ST_OFF;
          wake_cnt_q <= {WAKE_W{1'b0}};
          gnt_q      <= {N_REQ{1'b0}};
          idle_q     <= {IDLE_W{1'b0}};
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign tick = tick_s;
  assign ce   = gnt_q & {N_REQ{tick_s}};
  assign busy = busy_q;

`ifdef CLK_EN_SCHED_STATS_EN
  logic [31:0] tick_cnt_q;

  // Free-running tick statistics, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= 32'd0;
    end else if (tick_s) begin
      tick_cnt_q <= tick_cnt_q + 32'd1;
    end
  end

  assign tick_cnt = tick_cnt_q;
`else
  assign tick_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_clk_en_sched.sv
// Self-checking bench for clk_en_sched: directed scenarios followed by random
// traffic, all compared against a period/phase level reference model.
module tb_clk_en_sched;

  localparam int MD_OFF  = 0;
  localparam int MD_WAKE = 1;
  localparam int MD_RUN  = 2;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [7:0]  cfg_div;
  logic        cfg_div_vld;
  logic [5:0]  cfg_idle;
  logic [3:0]  gnt;
  logic        tick;
  logic [3:0]  ce;
  logic        busy;
  logic [31:0] tick_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int          m_mode;
  int          m_wake_done;
  int          m_phase;
  int          m_ratio;
  int          m_next;
  bit          m_has_next;
  logic [3:0]  m_gnt;
  int          m_idle_run;
  logic [31:0] m_ticks;

  clk_en_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .cfg_div     (cfg_div),
    .cfg_div_vld (cfg_div_vld),
    .cfg_idle    (cfg_idle),
    .gnt         (gnt),
    .tick        (tick),
    .ce          (ce),
    .busy        (busy),
    .tick_cnt    (tick_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_tick_now();
    // last cycle of a period of (ratio+1) cycles
    return (m_mode == MD_RUN) && (m_phase == (m_ratio + 1) - 1);
  endfunction

  function automatic logic [31:0] m_tick_cnt();
`ifdef CLK_EN_SCHED_STATS_EN
    return m_ticks;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    m_mode      = MD_OFF;
    m_wake_done = 0;
    m_phase     = 0;
    m_ratio     = 0;
    m_next      = 0;
    m_has_next  = 1'b0;
    m_gnt       = 4'h0;
    m_idle_run  = 0;
    m_ticks     = 32'd0;
  endtask

  // advance the model across one rising edge using the current inputs
  task automatic model_step();
    bit         t;
    logic [3:0] g_old;
    t     = m_tick_now();
    g_old = m_gnt;
    case (m_mode)
      MD_OFF: begin
        if (cfg_div_vld) begin
          m_ratio    = int'(cfg_div);
          m_has_next = 1'b0;
        end
        m_gnt      = 4'h0;
        m_idle_run = 0;
        if (req != 4'h0) begin
          m_mode      = MD_WAKE;
          m_wake_done = 0;
        end
      end
      MD_WAKE: begin
        if (cfg_div_vld) begin
          m_ratio    = int'(cfg_div);
          m_has_next = 1'b0;
        end
        m_wake_done++;
        if (m_wake_done == 4) begin
          m_mode  = MD_RUN;
          m_phase = 0;
          m_gnt   = req;
        end
      end
      default: begin
        if (t) begin
          m_ticks = m_ticks + 32'd1;
          m_gnt   = req;
          m_phase = 0;
          if (cfg_div_vld) begin
            m_ratio    = int'(cfg_div);
            m_has_next = 1'b0;
          end else if (m_has_next) begin
            m_ratio    = m_next;
            m_has_next = 1'b0;
          end
          if (req == 4'h0 && g_old == 4'h0) begin
            m_idle_run++;
            if (m_idle_run == int'(cfg_idle) + 1) begin
              m_mode     = MD_OFF;
              m_idle_run = 0;
            end
          end else begin
            m_idle_run = 0;
          end
        end else begin
          m_phase++;
          if (cfg_div_vld) begin
            m_next     = int'(cfg_div);
            m_has_next = 1'b1;
          end
        end
      end
    endcase
  endtask

  task automatic check_outputs();
    logic [3:0] exp_ce;
    exp_ce = m_tick_now() ? m_gnt : 4'h0;
    check_eq("tick", {31'd0, tick}, {31'd0, m_tick_now()});
    check_eq("gnt", {28'd0, gnt}, {28'd0, m_gnt});
    check_eq("ce", {28'd0, ce}, {28'd0, exp_ce});
    check_eq("busy", {31'd0, busy}, {31'd0, (m_mode != MD_OFF)});
    check_eq("tick_cnt", tick_cnt, m_tick_cnt());
  endtask

  // one clock: model follows the edge, outputs checked on the falling edge
  task automatic run_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  // assert reset between edges, check immediate clear, release on a falling edge
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_gnt", {28'd0, gnt}, 32'd0);
    check_eq("rst_tick", {31'd0, tick}, 32'd0);
    check_eq("rst_ce", {28'd0, ce}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_tick_cnt", tick_cnt, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();
  endtask

  initial begin
    bit got;
    rst_n       = 1'b0;
    req         = 4'h0;
    cfg_div     = 8'd0;
    cfg_div_vld = 1'b0;
    cfg_idle    = 6'd2;
    model_reset();
    #1;
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    check_eq("reset_gnt", {28'd0, gnt}, 32'd0);
    check_eq("reset_tick", {31'd0, tick}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();

    // 1: ratio 3 strobed in OFF, single requester wakes the domain
    cfg_div     = 8'd3;
    cfg_div_vld = 1'b1;
    run_cycle();
    cfg_div_vld = 1'b0;
    req         = 4'b0001;
    run_cycles(4 + 16);

    // 2: ratio change two cycles into a period
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (m_tick_now()) got = 1'b1;
      else run_cycle();
    end
    check_eq("wait_tick", {31'd0, got}, 32'd1);
    run_cycles(2);
    cfg_div     = 8'd1;
    cfg_div_vld = 1'b1;
    run_cycle();
    cfg_div_vld = 1'b0;
    run_cycles(12);

    // 3: requester 2 joins mid-period
    run_cycle();
    req = 4'b0101;
    run_cycles(12);

    // 4: all requests drop, idle timeout, then re-request
    req = 4'b0000;
    run_cycles(30);
    check_eq("idle_off_busy", {31'd0, busy}, 32'd0);
    req = 4'b0010;
    run_cycles(20);

    // 5: async reset mid-RUN with all requesters granted
    req = 4'b1111;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (m_mode == MD_RUN && m_gnt == 4'hF) got = 1'b1;
      else run_cycle();
    end
    check_eq("wait_full_gnt", {31'd0, got}, 32'd1);
    check_eq("pre_rst_gnt", {28'd0, gnt}, 32'hF);
    async_reset();
    req = 4'b0000;
    run_cycles(4);

    // random traffic segments with different idle limits
    for (int seg = 0; seg < 3; seg++) begin
      cfg_idle = (seg == 0) ? 6'd0 : ((seg == 1) ? 6'd3 : 6'd1);
      async_reset();
      for (int c = 0; c < 3000; c++) begin
        cfg_div     = 8'($urandom_range(0, 6));
        cfg_div_vld = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 15) == 0) begin
          if ($urandom_range(0, 1) == 0) req = 4'h0;
          else req = 4'($urandom_range(0, 15));
        end
        run_cycle();
      end
      cfg_div_vld = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
